// File: rtl/multi_adc_capture.sv
// Multi-channel LTC2315-class ADC capture: one shared CS/SCK pair, one SDO per channel,
// all channels delivered as one aligned word per sample period with block indexing.
module multi_adc_capture #(
  parameter int CHANNELS      = 2,
  parameter int DATA_BITS     = 12,
  parameter int LEAD_BITS     = 1,
  parameter int FRAME_BITS    = 16,
  parameter int SCK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int BLOCK_WORDS   = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             burst_mode,
  input  logic [CHANNELS-1:0]              adc_sdo,
  output logic                             adc_cs,
  output logic                             adc_sck,
  output logic                             sample_valid,
  output logic [16*CHANNELS-1:0]           sample_data,
  output logic [$clog2(BLOCK_WORDS)-1:0]   sample_index,
  output logic                             block_ready,
  output logic                             burst_done,
  output logic                             busy
);

  localparam int PC_W  = $clog2(SAMPLE_PERIOD);
  localparam int PH_W  = $clog2(SCK_DIV + 1);
  localparam int BC_W  = $clog2(FRAME_BITS + 1);
  localparam int IDX_W = $clog2(BLOCK_WORDS);

  localparam logic [PC_W-1:0]  FRAME_END  = PC_W'(2 * SCK_DIV * FRAME_BITS - 1);
  localparam logic [PC_W-1:0]  PERIOD_END = PC_W'(SAMPLE_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_END     = PH_W'(SCK_DIV - 1);
  localparam logic [BC_W-1:0]  LEAD_C     = BC_W'(LEAD_BITS);
  localparam logic [BC_W-1:0]  DATA_C     = BC_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CONV, HOLD} state_t;

  state_t                 state;
  logic [PC_W-1:0]        pcnt;
  logic [PH_W-1:0]        ph;
  logic [BC_W-1:0]        bcnt;
  logic [BC_W-1:0]        bit_rel;
  logic                   burst_r;
  logic                   sck_rise;
  logic                   in_win;
  logic                   vld_p0;
  logic [DATA_BITS-1:0]   data_p0 [CHANNELS];
  logic [16*CHANNELS-1:0] word_p0;

  // A rising SCK edge is produced (and SDO sampled) when the half-period divider
  // wraps while SCK is low; the frame-end cycle forces SCK low instead.
  assign sck_rise = (state == SHIFT) && (pcnt != FRAME_END) && (ph == PH_END) && !adc_sck;
  assign bit_rel  = bcnt - LEAD_C;
  assign in_win   = (bit_rel < DATA_C);

  // Stage p0: serial shift-in of the result window, MSB first
  always_ff @(posedge clk) begin
    if (sck_rise && in_win) begin
      for (int i = 0; i < CHANNELS; i++)
        data_p0[i] <= {data_p0[i][DATA_BITS-2:0], adc_sdo[i]};
    end
  end

  always_comb begin
    word_p0 = '0;
    for (int i = 0; i < CHANNELS; i++)
      word_p0[16*i +: DATA_BITS] = data_p0[i];
  end

  // Stage p1: sequencing, SCK/CS generation and the aligned output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pcnt         <= '0;
      ph           <= '0;
      bcnt         <= '0;
      burst_r      <= 1'b0;
      vld_p0       <= 1'b0;
      adc_cs       <= 1'b1;
      adc_sck      <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_index <= '0;
      block_ready  <= 1'b0;
      burst_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vld_p0       <= 1'b0;
      sample_valid <= vld_p0;
      block_ready  <= vld_p0 && (sample_index == IDX_LAST);
      if (vld_p0) begin
        sample_data <= word_p0;
        if (burst_r && (sample_index == IDX_LAST))
          burst_done <= 1'b1;
      end
      if (sample_valid)
        sample_index <= sample_index + 1'b1;

      case (state)
        IDLE: begin
          burst_r <= burst_mode;
          if (start && !burst_done) begin
            state  <= SHIFT;
            pcnt   <= '0;
            ph     <= '0;
            bcnt   <= '0;
            adc_cs <= 1'b0;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == FRAME_END) begin
            state   <= CONV;
            adc_cs  <= 1'b1;
            adc_sck <= 1'b0;
            vld_p0  <= 1'b1;
          end else if (ph == PH_END) begin
            ph      <= '0;
            adc_sck <= !adc_sck;
            if (!adc_sck)
              bcnt <= bcnt + 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        CONV: begin
          if (pcnt == PERIOD_END) begin
            pcnt <= '0;
            if (burst_done) begin
              state        <= HOLD;
              busy         <= 1'b0;
              sample_index <= '0;
            end else if (start) begin
              state  <= SHIFT;
              ph     <= '0;
              bcnt   <= '0;
              adc_cs <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        HOLD: begin
          if (!start) begin
            state      <= IDLE;
            burst_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
